decoder_3to8: RTL and testbench
===============================

Name: decoder_3to8

Overview:
- 3-to-8 line decoder with active-high enable and one-hot outputs Y7..Y0.
- Select code is {A,B,C}, with A as the MSB.
- Outputs are registered on one clock with an asynchronous active-low reset; an optional combinational bypass is available.
- Used as a generic address/select decoder feeding chip-select or mux-select logic.

Parameters:
- REGISTER_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = purely combinational from A/B/C/en (clk/rst_n unused).
- ACTIVE_LOW_OUT, 0, 1 = invert all eight outputs (selected line low, others high); reset/disabled value inverts accordingly.

Ports:
- clk  input  1  single clock; rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- A  input  1  select bit 2 (MSB).
- B  input  1  select bit 1.
- C  input  1  select bit 0 (LSB).
- en  input  1  decoder enable, active high.
- Y7..Y0  output  1 each  decoded lines; Yk corresponds to code k = {A,B,C}.
- Port declaration order is the order listed above; instances connect by name.

Behaviour:
- Decode function (ACTIVE_LOW_OUT=0):
  - Yk = en & ({A,B,C} == k), k = 0..7.
  - Exactly one output is high when en=1; all outputs are low when en=0.
- ACTIVE_LOW_OUT=1: each Yk is the bitwise complement of the function above.
- REGISTER_OUT=1:
  - The 8-bit output vector is captured on every clk rising edge from the current A, B, C, en.
  - Latency is 1 cycle; the output holds between edges.
  - Input changes between edges never glitch the outputs.
- Reset:
  - rst_n=0 immediately (asynchronously) forces all Y to the inactive value: 0, or 1 if ACTIVE_LOW_OUT.
  - Held while rst_n=0, regardless of clk and inputs.
  - Reset asserted mid-operation clears the outputs without waiting for an edge.
  - Release is synchronous in effect: the first rising edge with rst_n=1 loads the decoded value.
- en falling while a code is selected: outputs go inactive on the next edge (REGISTER_OUT=1) or immediately (REGISTER_OUT=0).
- Simultaneous select change and en change at the same edge: the output reflects both new values (single-cycle, no priority).
- Inputs X/Z: not required to be handled; the bench drives known values only.
- No internal state beyond the 8-bit output register.
- REGISTER_OUT=0: clk and rst_n are ignored.
- Invariant: outputs are never more than one-hot active.

Test Plan:
- Reset: rst_n=0, en=1, ABC=101 -> Y7..Y0=00000000 immediately and while held; release rst_n, next edge -> Y5=1, i.e. 00100000.
- Disabled: en=0, ABC=000 -> after one edge Y=00000000; en=1 -> next edge Y=00000001 (Y0).
- Sweep: en=1, ABC=010 -> Y=00000100; ABC=100 -> Y=00010000; ABC=110 -> Y=01000000; each appears exactly one clk edge after the input change.
- Disable mid-select: ABC=110, Y6 high, en->0 -> next edge Y=00000000; outputs stay stable between edges.
- Exhaustive: all 8 codes x en in {0,1} -> output has popcount 1 iff en=1 and the high bit index equals {A,B,C}.
- ACTIVE_LOW_OUT=1, REGISTER_OUT=0: en=1, ABC=011 -> Y=11110111 combinationally; en=0 -> Y=11111111.

Source files
------------

// File: rtl/decoder_3to8.sv
// 3-to-8 line decoder with active-high enable.
// Select code is {A,B,C} with A as MSB; output line Yk is active when the
// code equals k and en is high. Outputs are optionally registered (1-cycle
// latency, async active-low reset) and optionally active-low.
module decoder_3to8 #(
  parameter logic REGISTER_OUT   = 1'b1,
  parameter logic ACTIVE_LOW_OUT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic en,
  output logic Y7,
  output logic Y6,
  output logic Y5,
  output logic Y4,
  output logic Y3,
  output logic Y2,
  output logic Y1,
  output logic Y0
);

  // Value presented on every line when disabled or in reset.
  localparam logic [7:0] INACTIVE_VEC = {8{ACTIVE_LOW_OUT}};

  // One-hot decode of a 3-bit select, gated by enable (active-high form).
  function automatic logic [7:0] decode_f(input logic [2:0] sel, input logic enable);
    logic [7:0] onehot;
    case (sel)
      3'd0:    onehot = 8'b0000_0001;
      3'd1:    onehot = 8'b0000_0010;
      3'd2:    onehot = 8'b0000_0100;
      3'd3:    onehot = 8'b0000_1000;
      3'd4:    onehot = 8'b0001_0000;
      3'd5:    onehot = 8'b0010_0000;
      3'd6:    onehot = 8'b0100_0000;
      3'd7:    onehot = 8'b1000_0000;
      default: onehot = 8'b0000_0000;
    endcase
    if (enable) begin
      decode_f = onehot;
    end else begin
      decode_f = 8'b0000_0000;
    end
  endfunction

  logic [2:0] sel_s;
  logic [7:0] y_d;
  logic [7:0] y_out_s;

  assign sel_s = {A, B, C};

  // Next output vector: decoded lines, inverted when outputs are active-low.
  always_comb begin
    y_d = 8'b0000_0000;
    y_d = decode_f(sel_s, en) ^ INACTIVE_VEC;
  end

  generate
    if (REGISTER_OUT == 1'b1) begin : g_reg
      logic [7:0] y_q;

      // Capture the decoded vector each rising edge; reset forces inactive lines.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_q <= INACTIVE_VEC;
        end else begin
          y_q <= y_d;
        end
      end

      assign y_out_s = y_q;
    end else begin : g_comb
      // Clock and reset have no role in the purely combinational variant.
      logic unused_clk_rst_s;
      assign unused_clk_rst_s = clk ^ rst_n;
      assign y_out_s = y_d;
    end
  endgenerate

  assign {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0} = y_out_s;

endmodule

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8: a registered active-high instance and a
// combinational active-low instance share the same inputs and are compared
// against a behavioural model (shift-based one-hot, inverted for active-low).
module tb_decoder_3to8;

  logic clk;
  logic rst_n;
  logic A, B, C, en;

  logic r7, r6, r5, r4, r3, r2, r1, r0;
  logic c7, c6, c5, c4, c3, c2, c1, c0;
  logic [7:0] yr;
  logic [7:0] yc;

  int checks;
  int failures;

  assign yr = {r7, r6, r5, r4, r3, r2, r1, r0};
  assign yc = {c7, c6, c5, c4, c3, c2, c1, c0};

  decoder_3to8 #(.REGISTER_OUT(1'b1), .ACTIVE_LOW_OUT(1'b0)) u_reg (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .en(en),
    .Y7(r7), .Y6(r6), .Y5(r5), .Y4(r4), .Y3(r3), .Y2(r2), .Y1(r1), .Y0(r0)
  );

  decoder_3to8 #(.REGISTER_OUT(1'b0), .ACTIVE_LOW_OUT(1'b1)) u_comb (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .en(en),
    .Y7(c7), .Y6(c6), .Y5(c5), .Y4(c4), .Y3(c3), .Y2(c2), .Y1(c1), .Y0(c0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: line k active iff enabled and code == k.
  function automatic logic [7:0] model(input logic enable, input int code, input bit act_low);
    logic [7:0] v;
    v = enable ? 8'(32'd1 << code) : 8'h00;
    return act_low ? ~v : v;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic e, input int code);
    en = e;
    {A, B, C} = 3'(code);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int code;
    logic e;
    logic [7:0] pc;
    logic [7:0] idx;
    checks = 0;
    failures = 0;

    // Reset held with en=1, ABC=101
    rst_n = 1'b0;
    set_in(1'b1, 5);
    #2;
    check("reset_immediate", yr, 8'h00);
    check("comb_al_sel5", yc, model(1'b1, 5, 1'b1));
    tick();
    tick();
    check("reset_held", yr, 8'h00);
    rst_n = 1'b1;
    #2;
    check("reset_release_no_edge", yr, 8'h00);
    tick();
    check("reset_release_edge", yr, 8'b0010_0000);

    // Disabled then enabled on code 0
    set_in(1'b0, 0);
    tick();
    check("disabled", yr, 8'h00);
    set_in(1'b1, 0);
    #2;
    check("enable_before_edge", yr, 8'h00);
    tick();
    check("enable_y0", yr, 8'b0000_0001);

    // Sweep: value changes only at the edge after the input change
    set_in(1'b1, 2);
    #3;
    check("sweep2_hold", yr, 8'b0000_0001);
    tick();
    check("sweep2", yr, 8'b0000_0100);
    set_in(1'b1, 4);
    #3;
    check("sweep4_hold", yr, 8'b0000_0100);
    tick();
    check("sweep4", yr, 8'b0001_0000);
    set_in(1'b1, 6);
    tick();
    check("sweep6", yr, 8'b0100_0000);

    // Disable mid-select
    set_in(1'b0, 6);
    #3;
    check("disable_hold", yr, 8'b0100_0000);
    tick();
    check("disable_mid", yr, 8'h00);

    // Simultaneous select and enable change
    set_in(1'b1, 7);
    tick();
    check("simul_change", yr, 8'b1000_0000);

    // Exhaustive: popcount and active index
    for (int i = 0; i < 16; i++) begin
      code = i % 8;
      e = (i >= 8);
      set_in(e, code);
      tick();
      pc = 8'($countones(yr));
      idx = 8'd8;
      for (int k = 0; k < 8; k++) begin
        if (yr[k]) idx = 8'(k);
      end
      check("exh_popcount", pc, e ? 8'd1 : 8'd0);
      check("exh_index", idx, e ? 8'(code) : 8'd8);
      check("exh_comb", yc, model(e, code, 1'b1));
    end

    // Combinational active-low directed points
    set_in(1'b1, 3);
    #1;
    check("comb_al_011", yc, 8'b1111_0111);
    set_in(1'b0, 3);
    #1;
    check("comb_al_disabled", yc, 8'b1111_1111);

    // Randomized against the model
    for (int i = 0; i < 60; i++) begin
      code = int'($urandom_range(7, 0));
      e = 1'($urandom_range(1, 0));
      set_in(e, code);
      #1;
      check("rand_comb", yc, model(e, code, 1'b1));
      tick();
      check("rand_reg", yr, model(e, code, 1'b0));
    end

    // Reset asserted mid-operation clears without an edge
    set_in(1'b1, 3);
    tick();
    check("pre_midreset", yr, 8'b0000_1000);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_async", yr, 8'h00);
    tick();
    check("midreset_held", yr, 8'h00);
    rst_n = 1'b1;
    tick();
    check("midreset_release", yr, 8'b0000_1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
